hazard_stall_unit: RTL and testbench

Producer-side companion to the forwarding logic: a shadow pipeline tracks each in-flight instruction's destination register through the EX, MEM and WB stages. The block detects load-use hazards, asserts multi-cycle stalls, and injects bubbles. It handles taken-branch flushes. It drives the writeReg_MEM, writeReg_WB and readDataMEM_WB signals consumed by the forwarding unit, and sits beside the ID/EX pipeline registers.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hz_match.sv | 24 ++
 rtl/hazard_stall_unit.sv | 148 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the load-use stall unit.
// The shadow-entry rd field is HZ_REG_AW bits wide; a core with a wider
// register file widens HZ_REG_AW here and the unit's REG_AW together.
package hazard_pkg;

  localparam int HZ_REG_AW = 5;
  localparam int HZ_CNT_W  = 3;
  localparam int REG_X0    = 0;

  typedef struct packed {
    logic                 valid;
    logic [HZ_REG_AW-1:0] rd;
    logic                 regWrite;
    logic                 memRead;
  } hz_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  // Destination as seen by the forwarding unit: x0 when the entry is not a live writer.
  function automatic logic [HZ_REG_AW-1:0] effRd(input hz_entry_t e);
    return (e.valid && e.regWrite) ? e.rd : HZ_REG_AW'(REG_X0);
  endfunction

endpackage

// File: rtl/hz_match.sv
// hz_match: does one decode source register depend on an in-flight load
// whose data is not yet available?
module hz_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW
) (
  input  logic [REG_AW-1:0] srcReg_i,
  input  logic              srcUsed_i,
  input  hz_entry_t         entry_i,
  output logic              hit_o
);

  // A hit needs a real load that writes a non-x0 register matching the source.
  always_comb begin
    hit_o = srcUsed_i
          & entry_i.valid
          & entry_i.memRead
          & entry_i.regWrite
          & (entry_i.rd != HZ_REG_AW'(REG_X0))
          & (HZ_REG_AW'(srcReg_i) == entry_i.rd);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: shadow pipeline of destination registers (EX/MEM/WB),
// load-use stall generation and taken-branch flush control.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYC = 1,
  parameter int REG_AW         = HZ_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              useRs1_ID,
  input  logic              useRs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              regWrite_ID,
  input  logic              memRead_ID,
  input  logic              branchTaken_EX,
  output logic              stall_IF,
  output logic              stall_ID,
  output logic              bubble_EX,
  output logic              flush_ID,
  output logic [REG_AW-1:0] writeReg_MEM,
  output logic [REG_AW-1:0] writeReg_WB,
  output logic              readDataMEM_WB
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stallCount,
  output logic [31:0]       flushCount
`endif
);

  hz_entry_t             eEx_q, eMem_q, eWb_q, eEx_d;
  hz_state_t             state_q, state_d;
  logic [HZ_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  live_q;
  logic                  hitRs1, hitRs2;
  logic                  hazard, brTaken;
  logic                  stallRaw, bubbleRaw, flushRaw;

  hz_match #(.REG_AW(REG_AW)) u_matchRs1 (
    .srcReg_i  (rs1_ID),
    .srcUsed_i (useRs1_ID),
    .entry_i   (eEx_q),
    .hit_o     (hitRs1)
  );

  hz_match #(.REG_AW(REG_AW)) u_matchRs2 (
    .srcReg_i  (rs2_ID),
    .srcUsed_i (useRs2_ID),
    .entry_i   (eEx_q),
    .hit_o     (hitRs2)
  );

  // live_q masks every control output during the first cycle after reset release.
  assign hazard  = live_q & valid_ID & (hitRs1 | hitRs2);
  assign brTaken = live_q & branchTaken_EX;

  // Control decode: flush beats an active stall, which beats a new hazard.
  always_comb begin
    stallRaw  = 1'b0;
    bubbleRaw = 1'b0;
    flushRaw  = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (brTaken) begin
      flushRaw  = 1'b1;
      bubbleRaw = 1'b1;
      state_d   = RUN;
      cnt_d     = '0;
    end else if (state_q == STALL) begin
      stallRaw  = 1'b1;
      bubbleRaw = 1'b1;
      if (cnt_q <= HZ_CNT_W'(1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - HZ_CNT_W'(1);
      end
    end else if (hazard) begin
      stallRaw  = 1'b1;
      bubbleRaw = 1'b1;
      if (LOAD_STALL_CYC > 1) begin
        state_d = STALL;
        cnt_d   = HZ_CNT_W'(LOAD_STALL_CYC - 1);
      end
    end
  end

  // Next EX entry: the decode instruction, or an empty slot when a bubble goes in.
  always_comb begin
    eEx_d = '0;
    if (!bubbleRaw) begin
      eEx_d.valid    = valid_ID;
      eEx_d.rd       = HZ_REG_AW'(rd_ID);
      eEx_d.regWrite = regWrite_ID;
      eEx_d.memRead  = memRead_ID;
    end
  end

  // Shadow pipeline and FSM state; MEM and WB always advance, even under a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      live_q  <= 1'b0;
      eEx_q   <= '0;
      eMem_q  <= '0;
      eWb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      eEx_q   <= eEx_d;
      eMem_q  <= eEx_q;
      eWb_q   <= eMem_q;
    end
  end

  assign stall_IF       = stallRaw;
  assign stall_ID       = stallRaw;
  assign bubble_EX      = bubbleRaw;
  assign flush_ID       = flushRaw;
  assign writeReg_MEM   = REG_AW'(effRd(eMem_q));
  assign writeReg_WB    = REG_AW'(effRd(eWb_q));
  assign readDataMEM_WB = eWb_q.valid & eWb_q.memRead;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt_q, flushCnt_q;

  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stallRaw && (stallCnt_q != 32'hFFFF_FFFF)) stallCnt_q <= stallCnt_q + 32'd1;
      if (flushRaw && (flushCnt_q != 32'hFFFF_FFFF)) flushCnt_q <= flushCnt_q + 32'd1;
    end
  end

  assign stallCount = stallCnt_q;
  assign flushCount = flushCnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: drives one instruction stream into two copies of the
// unit (1-cycle and 3-cycle load stalls) and scores both against a model.
module tb_hazard_stall_unit;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          valid_ID;
  logic [AW-1:0] rs1_ID, rs2_ID, rd_ID;
  logic          useRs1_ID, useRs2_ID, regWrite_ID, memRead_ID, branchTaken_EX;

  logic [1:0]    stallIFv, stallIDv, bubbleV, flushV, rdWbV;
  logic [AW-1:0] wMemV [2];
  logic [AW-1:0] wWbV  [2];
  logic [31:0]   sCntV [2];
  logic [31:0]   fCntV [2];

  hazard_stall_unit #(.LOAD_STALL_CYC(1), .REG_AW(AW)) u_dutL1 (
    .clk(clk), .reset(reset), .valid_ID(valid_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .useRs1_ID(useRs1_ID), .useRs2_ID(useRs2_ID),
    .rd_ID(rd_ID), .regWrite_ID(regWrite_ID), .memRead_ID(memRead_ID),
    .branchTaken_EX(branchTaken_EX),
    .stall_IF(stallIFv[0]), .stall_ID(stallIDv[0]), .bubble_EX(bubbleV[0]),
    .flush_ID(flushV[0]), .writeReg_MEM(wMemV[0]), .writeReg_WB(wWbV[0]),
    .readDataMEM_WB(rdWbV[0])
`ifdef HAZARD_PERF_EN
    , .stallCount(sCntV[0]), .flushCount(fCntV[0])
`endif
  );

  hazard_stall_unit #(.LOAD_STALL_CYC(3), .REG_AW(AW)) u_dutL3 (
    .clk(clk), .reset(reset), .valid_ID(valid_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .useRs1_ID(useRs1_ID), .useRs2_ID(useRs2_ID),
    .rd_ID(rd_ID), .regWrite_ID(regWrite_ID), .memRead_ID(memRead_ID),
    .branchTaken_EX(branchTaken_EX),
    .stall_IF(stallIFv[1]), .stall_ID(stallIDv[1]), .bubble_EX(bubbleV[1]),
    .flush_ID(flushV[1]), .writeReg_MEM(wMemV[1]), .writeReg_WB(wWbV[1]),
    .readDataMEM_WB(rdWbV[1])
`ifdef HAZARD_PERF_EN
    , .stallCount(sCntV[1]), .flushCount(fCntV[1])
`endif
  );

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
  } ent_t;

  typedef struct packed {
    logic          stallIF;
    logic          stallID;
    logic          bubble;
    logic          flush;
    logic [AW-1:0] wMem;
    logic [AW-1:0] wWb;
    logic          rdWb;
    logic [31:0]   sCnt;
    logic [31:0]   fCnt;
  } exp_t;

  exp_t expQ0[$];
  exp_t expQ1[$];

  // Model state: instructions in flight (index 0 = youngest = EX) and stall cycles owed.
  ent_t pipe      [2][3];
  int   stallLeft [2];
  int   stallNext [2];
  bit   live      [2];
  bit   bubNext   [2];
  bit   stallNow  [2];
  bit   flushNow  [2];
  int   sCnt      [2];
  int   fCnt      [2];
  bit   rstPrev;

  int nChecks = 0;
  int nFails  = 0;

  function automatic int stallLen(input int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic void modelReset(input int m);
    for (int i = 0; i < 3; i++) pipe[m][i] = '0;
    stallLeft[m] = 0;
    stallNext[m] = 0;
    live[m]      = 1'b0;
    bubNext[m]   = 1'b0;
    stallNow[m]  = 1'b0;
    flushNow[m]  = 1'b0;
    sCnt[m]      = 0;
    fCnt[m]      = 0;
  endfunction

  // Clock edge: everything in flight moves one stage older; a bubble enters as empty.
  function automatic void modelEdge(input int m);
    ent_t incoming;
    if (rstPrev) return;
    incoming = '0;
    if (!bubNext[m]) incoming = '{valid_ID, rd_ID, regWrite_ID, memRead_ID};
    sCnt[m] += int'(stallNow[m]);
    fCnt[m] += int'(flushNow[m]);
    pipe[m][2]   = pipe[m][1];
    pipe[m][1]   = pipe[m][0];
    pipe[m][0]   = incoming;
    stallLeft[m] = stallNext[m];
    live[m]      = 1'b1;
  endfunction

  function automatic exp_t computeExp(input int m);
    exp_t e;
    ent_t ex, mem, wb;
    bit   hz;
    e = '0;
    stallNow[m]  = 1'b0;
    flushNow[m]  = 1'b0;
    bubNext[m]   = 1'b0;
    stallNext[m] = stallLeft[m];
    if (reset) begin
      stallNext[m] = 0;
      return e;
    end
    ex  = pipe[m][0];
    mem = pipe[m][1];
    wb  = pipe[m][2];
    hz  = live[m] && ex.v && ex.mr && ex.rw && (ex.rd != 0) && valid_ID &&
          ((useRs1_ID && rs1_ID == ex.rd) || (useRs2_ID && rs2_ID == ex.rd));
    if (live[m] && branchTaken_EX) begin
      flushNow[m]  = 1'b1;
      bubNext[m]   = 1'b1;
      stallNext[m] = 0;
    end else if (stallLeft[m] > 0) begin
      stallNow[m]  = 1'b1;
      bubNext[m]   = 1'b1;
      stallNext[m] = stallLeft[m] - 1;
    end else if (hz) begin
      stallNow[m]  = 1'b1;
      bubNext[m]   = 1'b1;
      stallNext[m] = stallLen(m) - 1;
    end
    e.stallIF = stallNow[m];
    e.stallID = stallNow[m];
    e.bubble  = bubNext[m];
    e.flush   = flushNow[m];
    e.wMem    = (mem.v && mem.rw) ? mem.rd : '0;
    e.wWb     = (wb.v && wb.rw) ? wb.rd : '0;
    e.rdWb    = wb.v && wb.mr;
    e.sCnt    = 32'(sCnt[m]);
    e.fCnt    = 32'(fCnt[m]);
    return e;
  endfunction

  // One cycle of stimulus: settle the model on the edge, drive, predict, enqueue.
  task automatic applyStimulus(input logic rst, input logic v,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                               input logic u1, input logic u2,
                               input logic [AW-1:0] rd, input logic rw,
                               input logic mr, input logic br);
    @(posedge clk);
    #1;
    modelEdge(0);
    modelEdge(1);
    reset          = rst;
    valid_ID       = v;
    rs1_ID         = r1;
    rs2_ID         = r2;
    useRs1_ID      = u1;
    useRs2_ID      = u2;
    rd_ID          = rd;
    regWrite_ID    = rw;
    memRead_ID     = mr;
    branchTaken_EX = br;
    rstPrev        = rst;
    if (rst) begin
      modelReset(0);
      modelReset(1);
    end
    expQ0.push_back(computeExp(0));
    expQ1.push_back(computeExp(1));
  endtask

  task automatic issue(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic u1, input logic u2,
                       input logic [AW-1:0] rd, input logic rw, input logic mr);
    applyStimulus(1'b0, 1'b1, r1, r2, u1, u2, rd, rw, mr, 1'b0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic void checkVal(input string name, input int m,
                                   input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFails++;
      $display("[TB] FAIL %s dut%0d t=%0t got %0h expected %0h", name, m, $time, act, want);
    end
  endfunction

  task automatic checkOutput(input int m, input exp_t e);
    checkVal("stall_IF",       m, 32'(stallIFv[m]), 32'(e.stallIF));
    checkVal("stall_ID",       m, 32'(stallIDv[m]), 32'(e.stallID));
    checkVal("bubble_EX",      m, 32'(bubbleV[m]),  32'(e.bubble));
    checkVal("flush_ID",       m, 32'(flushV[m]),   32'(e.flush));
    checkVal("writeReg_MEM",   m, 32'(wMemV[m]),    32'(e.wMem));
    checkVal("writeReg_WB",    m, 32'(wWbV[m]),     32'(e.wWb));
    checkVal("readDataMEM_WB", m, 32'(rdWbV[m]),    32'(e.rdWb));
`ifdef HAZARD_PERF_EN
    checkVal("stallCount",     m, sCntV[m],         e.sCnt);
    checkVal("flushCount",     m, fCntV[m],         e.fCnt);
`endif
  endtask

  // Monitor: mid-cycle, pop each unit's prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ0.size() > 0) begin
        e = expQ0.pop_front();
        checkOutput(0, e);
      end
      if (expQ1.size() > 0) begin
        e = expQ1.pop_front();
        checkOutput(1, e);
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized stream.
  initial begin
    reset = 1'b1; valid_ID = 1'b0; rs1_ID = '0; rs2_ID = '0; rd_ID = '0;
    useRs1_ID = 1'b0; useRs2_ID = 1'b0; regWrite_ID = 1'b0; memRead_ID = 1'b0;
    branchTaken_EX = 1'b0;
    rstPrev = 1'b1;
    modelReset(0);
    modelReset(1);

    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    nop(2);

    // lw x5 ; add x6,x5,x1
    issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    repeat (3) issue(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    nop(3);

    // lw x7 ; sub x8,x2,x7
    issue(5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    repeat (4) issue(5'd2, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    nop(2);

    // lw x0 ; add x1,x0,x0
    issue(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
    nop(3);

    // lw x9 ; dependent add, then a taken branch while the 3-cycle unit stalls
    issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    issue(5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
    nop(3);

    // add x3 ; add x4,x3,x3
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    issue(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    nop(3);

    // reset pulsed while stalling, then a fresh dependent pair
    issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1);
    issue(5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1, 1'b1);
    issue(5'd13, 5'd13, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    nop(4);

    // randomized traffic over a small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 7) != 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 9) == 0));
    end
    nop(3);

    for (int i = 0; i < 20 && (expQ0.size() > 0 || expQ1.size() > 0); i++) begin
      @(negedge clk);
      #1;
    end
    nChecks++;
    if (expQ0.size() != 0 || expQ1.size() != 0) begin
      nFails++;
      $display("[TB] FAIL drain got %0d/%0d pending expected 0", expQ0.size(), expQ1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
